byte_word_loader: RTL and testbench

// - Upstream stage of the 16-bit load register: gathers a byte stream into WIDTH-bit words.
// - Drives the register's data_in bus (data_out) and its one-cycle load strobe (load).
// - Handles partial-word timeout and flush, and keeps a count of committed words.

---
 rtl/byte_word_loader.sv | 143 ++++++++++++++
 tb/tb_byte_word_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_loader.sv
// Byte-to-word loader: gathers an 8-bit byte stream into WIDTH-bit words and
// presents each completed word with a one-cycle load strobe for the downstream
// load register. Drops partial words on timeout or flush.
module byte_word_loader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    input  logic             flush,
    input  logic             clr_err,
    output logic             load,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] word_count,
    output logic             timeout_err,
    output logic             busy
);

    localparam int unsigned NumBytes = WIDTH / 8;
    localparam int unsigned IdxW     = $clog2(NumBytes + 1);
    localparam int unsigned IdleW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [IdleW-1:0]   idle_q, idle_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               accept;
    logic               timeout_hit;
    logic [WIDTH-1:0]   shifted;

    // Handshake and status outputs; in_ready is gated by reset so it reads 0 while held.
    always_comb begin
        in_ready    = reset & (state_q != StCommit) & ~flush;
        accept      = in_valid & in_ready;
        load        = (state_q == StCommit);
        busy        = (state_q != StIdle);
        data_out    = data_q;
        word_count  = count_q;
        timeout_err = err_q;
    end

    // Shift register input: after NumBytes shifts the first byte lands at the chosen end.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted = {in_byte, shift_q[WIDTH-1:8]};
        end else begin
            shifted = {shift_q[WIDTH-9:0], in_byte};
        end
    end

    // Next-state: byte gathering, commit, flush and idle timeout.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        shift_d     = shift_q;
        data_d      = data_q;
        count_d     = count_q;
        err_d       = err_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = shifted;
                    idx_d   = IdxW'(1);
                    idle_d  = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (flush) begin
                    // Flush wins over timeout; in_ready is low so no byte is taken.
                    state_d = StIdle;
                    idx_d   = '0;
                    idle_d  = '0;
                end else if (accept) begin
                    shift_d = shifted;
                    idle_d  = '0;
                    if (idx_q == IdxW'(NumBytes - 1)) begin
                        state_d = StCommit;
                        idx_d   = '0;
                        data_d  = shifted;
                        count_d = count_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (TIMEOUT != 0) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == IdleW'(TIMEOUT)) begin
                        state_d     = StIdle;
                        idx_d       = '0;
                        idle_d      = '0;
                        timeout_hit = 1'b1;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A timeout in the same cycle beats a clear request.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            idle_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_byte_word_loader.sv
// Bench for byte_word_loader: two instances (LSB-first and MSB-first) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_byte_word_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        flush = 1'b0;
    logic        clr_err = 1'b0;

    logic        rdy_l, load_l, err_l, busy_l;
    logic [15:0] data_l;
    logic [1:0]  cnt_l;
    logic        rdy_m, load_m, err_m, busy_m;
    logic [15:0] data_m;
    logic [1:0]  cnt_m;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  pend[$];
    int          m_idle;
    bit          m_commit;
    logic [15:0] m_lsb, m_msb;
    int          m_cnt;
    bit          m_err;

    always #5 clk = ~clk;

    byte_word_loader #(.WIDTH(16), .LSB_FIRST(1), .TIMEOUT(4), .CNT_W(2)) u_dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_l), .flush(flush), .clr_err(clr_err), .load(load_l),
        .data_out(data_l), .word_count(cnt_l), .timeout_err(err_l), .busy(busy_l)
    );

    byte_word_loader #(.WIDTH(16), .LSB_FIRST(0), .TIMEOUT(4), .CNT_W(2)) u_dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_m), .flush(flush), .clr_err(clr_err), .load(load_m),
        .data_out(data_m), .word_count(cnt_m), .timeout_err(err_m), .busy(busy_m)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_idle   = 0;
        m_commit = 0;
        m_lsb    = '0;
        m_msb    = '0;
        m_cnt    = 0;
        m_err    = 0;
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        logic exp_busy;
        exp_rdy  = reset && !m_commit && !flush;
        exp_busy = m_commit || (pend.size() != 0);
        check_eq("ready_l", 32'(rdy_l),  32'(exp_rdy));
        check_eq("ready_m", 32'(rdy_m),  32'(exp_rdy));
        check_eq("load_l",  32'(load_l), 32'(m_commit));
        check_eq("load_m",  32'(load_m), 32'(m_commit));
        check_eq("busy_l",  32'(busy_l), 32'(exp_busy));
        check_eq("busy_m",  32'(busy_m), 32'(exp_busy));
        check_eq("data_l",  32'(data_l), 32'(m_lsb));
        check_eq("data_m",  32'(data_m), 32'(m_msb));
        check_eq("count_l", 32'(cnt_l),  32'(m_cnt));
        check_eq("count_m", 32'(cnt_m),  32'(m_cnt));
        check_eq("err_l",   32'(err_l),  32'(m_err));
        check_eq("err_m",   32'(err_m),  32'(m_err));
    endtask

    // Advance the model across one rising edge given the inputs of that cycle.
    task automatic model_edge(input bit v, input logic [7:0] b, input bit f, input bit c);
        bit acc;
        bit tset;
        acc  = v && !m_commit && !f;
        tset = 0;
        if (m_commit) begin
            m_commit = 0;
        end else if (pend.size() != 0) begin
            if (f) begin
                pend.delete();
                m_idle = 0;
            end else if (acc) begin
                pend.push_back(b);
                m_idle = 0;
                if (pend.size() == 2) begin
                    m_lsb    = {pend[1], pend[0]};
                    m_msb    = {pend[0], pend[1]};
                    m_cnt    = (m_cnt + 1) % 4;
                    m_commit = 1;
                    pend.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == 4) begin
                    pend.delete();
                    m_idle = 0;
                    tset   = 1;
                end
            end
        end else if (acc) begin
            pend.push_back(b);
            m_idle = 0;
        end
        if (tset) m_err = 1;
        else if (c) m_err = 0;
    endtask

    // One clock cycle: drive on the falling edge, check, then update the model.
    task automatic step(input bit v, input logic [7:0] b, input bit f, input bit c);
        @(negedge clk);
        in_valid = v;
        in_byte  = b;
        flush    = f;
        clr_err  = c;
        #1;
        check_outputs();
        model_edge(v, b, f, c);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        clr_err  = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        int pv;
        bit v, f, c;
        model_reset();
        do_reset();

        // Basic word and byte order
        send(8'hAA); send(8'hAA); idle(1);
        send(8'h34); send(8'h12); idle(1);
        send(8'h12); send(8'h34); idle(1);

        // Timeout drops the partial word, then recovery and clear
        send(8'h34); idle(4);
        send(8'h78); send(8'h56); idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b1); idle(1);

        // Back-to-back stream: in_ready low only in commit cycles
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        send(8'h06); idle(2);

        // Flush with a concurrent byte that must not be taken
        send(8'h34); step(1'b1, 8'h99, 1'b1, 1'b0);
        send(8'h11); send(8'h22); idle(1);
        step(1'b1, 8'h55, 1'b1, 1'b0); idle(1);

        // Timeout and clear in the same cycle: timeout wins
        send(8'h34); idle(3); step(1'b0, 8'h00, 1'b0, 1'b1); idle(1);

        // Reset mid-collect, then counter wrap over five words
        send(8'h77); do_reset();
        for (int w = 0; w < 5; w++) begin
            send(8'(w)); send(8'(w + 8'h10));
        end
        idle(2);

        // Randomized traffic with varying valid density
        pv = 90;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: pv = 90;
                    1: pv = 50;
                    default: pv = 10;
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 99) < pv);
                f = ($urandom_range(0, 29) == 0);
                c = ($urandom_range(0, 19) == 0);
                step(v, 8'($urandom), f, c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
